cache_line_fill: RTL

Parametrised miss-handling controller for the L1 instruction and data caches. It replaces the fixed 8-word, single-outstanding-counter fill machine with configurable line size, address and data width. It separates request issue from response collection, so a pipelined memory can return words while later addresses are still being issued. It sits between the cache tag-match logic and the memory bus, drives the data-array and tag-array write enables, and stalls the pipeline for the duration of a fill.

---
 rtl/cache_line_fill.sv | 129 ++++++++++++
 1 files changed

// File: rtl/cache_line_fill.sv
// Cache line fill controller: issues WORDS requests, collects in-order responses, then writes the tag.
// Latency: first request the cycle after the miss is accepted; tag write one cycle after the last data write.
// Backpressure: mem_addr holds while mem_req && !mem_ready; fsm_busy stalls the pipeline. Option: CACHE_CRIT_WORD_FIRST_EN.
module cache_line_fill #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              mem_ready,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_data,
    output logic              fsm_busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              write_data_array,
    output logic [$clog2(WORDS)-1:0] data_word_sel,
    output logic [DATA_W-1:0] data_out,
    output logic              write_tag_array,
    output logic              crit_word_valid
);
    localparam int OFF_W  = $clog2(WORDS);
    localparam int BASE_W = ADDR_W - OFF_W - 1;
    localparam logic [OFF_W:0] CNT_ONE = {{OFF_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, FILL, TAG} state_t;

    state_t             state, state_nxt;
    logic [BASE_W-1:0]  base;
    logic [OFF_W-1:0]   miss_off;
    logic [OFF_W-1:0]   start;
    logic [OFF_W:0]     req_cnt, rsp_cnt;
    logic [OFF_W-1:0]   req_off, rsp_off;
    logic               miss_acc, req_fire, rsp_acc;
    logic               addr_lsb_unused;

    // Byte bit of a word address carries no information.
    assign addr_lsb_unused = miss_address[0];

`ifdef CACHE_CRIT_WORD_FIRST_EN
    assign start = miss_off;
`else
    assign start = '0;
`endif

    assign req_off  = start + req_cnt[OFF_W-1:0];
    assign rsp_off  = start + rsp_cnt[OFF_W-1:0];
    assign data_out = mem_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base     <= '0;
            miss_off <= '0;
            req_cnt  <= '0;
            rsp_cnt  <= '0;
        end else if (miss_acc) begin
            base     <= miss_address[ADDR_W-1:OFF_W+1];
            miss_off <= miss_address[OFF_W:1];
            req_cnt  <= '0;
            rsp_cnt  <= '0;
        end else begin
            if (req_fire) begin
                req_cnt <= req_cnt + CNT_ONE;
            end
            if (rsp_acc) begin
                rsp_cnt <= rsp_cnt + CNT_ONE;
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        fsm_busy         = 1'b0;
        mem_req          = 1'b0;
        mem_addr         = '0;
        write_data_array = 1'b0;
        data_word_sel    = '0;
        crit_word_valid  = 1'b0;
        write_tag_array  = 1'b0;
        miss_acc         = 1'b0;
        req_fire         = 1'b0;
        rsp_acc          = 1'b0;
        case (state)
            IDLE: begin
                fsm_busy = miss_detected;
                miss_acc = miss_detected;
                if (miss_detected) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                // Counters saturate at WORDS, so the MSB alone marks "all issued".
                mem_req  = !req_cnt[OFF_W];
                mem_addr = {base, req_off, 1'b0};
                req_fire = mem_req && mem_ready;
                // A response is only valid against a request already accepted.
                rsp_acc  = mem_data_valid && (rsp_cnt < req_cnt);
                if (rsp_acc) begin
                    write_data_array = 1'b1;
                    data_word_sel    = rsp_off;
                    crit_word_valid  = (rsp_off == miss_off);
                    if (&rsp_cnt[OFF_W-1:0]) begin
                        state_nxt = TAG;
                    end
                end
            end
            TAG: begin
                fsm_busy        = 1'b1;
                write_tag_array = 1'b1;
                state_nxt       = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule
